// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiply unit.
package mul_pkg;

  // Controller states: waiting for a request, shifting/adding, writing the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand width (matches the register file data path).
  localparam int MUL_WIDTH = 32;

  // Full product width for the default operand width.
  localparam int MUL_PROD_W = 2 * MUL_WIDTH;

endpackage

// File: rtl/iterative_multiplier.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle on operand
// magnitudes, with the sign applied to the finished product.
module iterative_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [0:WIDTH-1] opA,
  input  logic [0:WIDTH-1] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int PW = 2 * WIDTH;

  // Operand buses are numbered with bit 0 as the MSB; copying into a
  // descending vector keeps the numeric value and puts the MSB at WIDTH-1.
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  assign a_val = opA;
  assign b_val = opB;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [PW:0]      acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic             neg_reg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   upper_next;
  logic [PW:0]      acc_next;
  logic [PW-1:0]    product;
  logic [PW-1:0]    result_next;

  // Operand magnitudes, one shift-add step, and the signed final product.
  always_comb begin
    a_neg = is_signed & a_val[WIDTH-1];
    b_neg = is_signed & b_val[WIDTH-1];
    // The most-negative value negates to itself, which read as unsigned
    // is exactly its magnitude.
    a_mag = a_neg ? -a_val : a_val;
    b_mag = b_neg ? -b_val : b_val;

    // Upper half keeps one extra bit so the carry of the add survives the shift.
    sum        = acc_reg[PW:WIDTH] + {1'b0, mcand_reg};
    upper_next = mplier_reg[0] ? sum : acc_reg[PW:WIDTH];
    acc_next   = {upper_next, acc_reg[WIDTH-1:0]} >> 1;

    product     = acc_reg[PW-1:0];
    result_next = neg_reg ? -product : product;
  end

  assign busy = (state_reg != IDLE);

  // Controller and datapath registers; outputs are registered here as well.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      neg_reg    <= 1'b0;
      done       <= 1'b0;
      result_lo  <= '0;
      result_hi  <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mcand_reg  <= a_mag;
            mplier_reg <= b_mag;
            neg_reg    <= a_neg ^ b_neg;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          acc_reg    <= acc_next;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          result_lo <= result_next[WIDTH-1:0];
          result_hi <= result_next[PW-1:WIDTH];
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_multiplier.sv
// Directed bench for iterative_multiplier with a queue-based result scoreboard.
module tb_iterative_multiplier;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;

  int tests_run;
  int tests_failed;

  logic [63:0] exp_q[$];

  iterative_multiplier #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .opA       (opA),
    .opB       (opB),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Independent reference product.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Drive a request; if wait_edge is set, first move to a fresh negedge.
  // Returns just after the accepting edge (one negedge later).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn, input bit wait_edge);
    if (wait_edge) @(negedge clk);
    opA = a;
    opB = b;
    is_signed = sgn;
    start = 1'b1;
    exp_q.push_back(ref_mul(a, b, sgn));
    $display("[TB] issue a=0x%08h b=0x%08h signed=%0d", a, b, sgn);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; e0 is the number of edges already elapsed since
  // the accepting edge. Reports edges to done, busy cycles seen, and whether
  // result_lo stayed put while waiting.
  task automatic wait_done(input int e0, output int edges, output int busy_cnt, output bit lo_stable);
    logic [31:0] lo0;
    edges = e0;
    busy_cnt = 0;
    lo_stable = 1'b1;
    lo0 = result_lo;
    while (!done && edges < 100) begin
      if (busy) busy_cnt++;
      if (result_lo !== lo0) lo_stable = 1'b0;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic check_result(input string tag);
    logic [63:0] exp_v;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      exp_v = exp_q.pop_front();
      check({tag, "_prod"}, {result_hi, result_lo}, exp_v);
      $display("[TB] %s result=0x%08h_%08h expected=0x%016h", tag, result_hi, result_lo, exp_v);
    end
  endtask

  initial begin
    int  edges;
    int  bcnt;
    bit  stable;
    bit  saw_done;

    tests_run = 0;
    tests_failed = 0;
    reset = 1'b0;
    start = 1'b0;
    is_signed = 1'b0;
    opA = '0;
    opB = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", {result_hi, result_lo}, 64'd0);
    reset = 1'b1;

    // Reset in the middle of a run
    issue(32'd7, 32'd9, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    check("mid_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_result", {result_hi, result_lo}, 64'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("mid_rst_no_done", {63'd0, saw_done}, 64'd0);
    $display("[TB] reset mid-run checked");

    // Recovery after reset
    issue(32'd7, 32'd9, 1'b0, 1'b1);
    wait_done(0, edges, bcnt, stable);
    check("after_rst_edges", 64'(edges), 64'd33);
    check_result("after_rst");

    // Unsigned max, with latency and busy window
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_done(0, edges, bcnt, stable);
    check("umax_edges", 64'(edges), 64'd33);
    check("umax_busy", 64'(bcnt), 64'd33);
    check("umax_done_busy", {63'd0, busy}, 64'd0);
    check("umax_const", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
    check_result("umax");
    @(negedge clk);
    check("umax_done_pulse", {63'd0, done}, 64'd0);
    check("umax_hold", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);

    // Signed and unsigned views of the same operands
    issue(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1);
    wait_done(0, edges, bcnt, stable);
    check("smix_const", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    check_result("smix");
    issue(32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1);
    wait_done(0, edges, bcnt, stable);
    check("umix_const", {result_hi, result_lo}, 64'h0000_0004_FFFF_FFF1);
    check_result("umix");

    // Corners: most-negative squared, zero operand
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    wait_done(0, edges, bcnt, stable);
    check("minneg_const", {result_hi, result_lo}, 64'h4000_0000_0000_0000);
    check_result("minneg");
    issue(32'd0, 32'h1234_5678, 1'b1, 1'b1);
    wait_done(0, edges, bcnt, stable);
    check_result("zero");
    issue(32'h1234_5678, 32'hFEDC_BA98, 1'b1, 1'b1);
    wait_done(0, edges, bcnt, stable);
    check_result("s_rand");

    // Start during a run is ignored; operand changes have no effect
    issue(32'd6, 32'd7, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    opA = 32'd2;
    opB = 32'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    opA = 32'hDEAD_BEEF;
    wait_done(5, edges, bcnt, stable);
    check("ign_edges", 64'(edges), 64'd33);
    check("ign_lo", {32'd0, result_lo}, 64'd42);
    check_result("ign");

    // Back-to-back: next start in the done cycle
    issue(32'd3, 32'd4, 1'b0, 1'b0);
    wait_done(0, edges, bcnt, stable);
    check("b2b_edges", 64'(edges), 64'd33);
    check("b2b_lo_stable", {63'd0, stable}, 64'd1);
    check_result("b2b");
    @(negedge clk);
    check("b2b_idle", {63'd0, busy}, 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
